grover_diffusion: RTL



---
 rtl/grover_pkg.sv | 18 +
 rtl/grover_sat_narrow.sv | 28 ++
 rtl/grover_diffusion.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/grover_pkg.sv
// Shared types and constants for the Grover amplitude stages.
package grover_pkg;

    localparam int NUM_BIT    = 3;
    localparam int AMP_W      = 8;
    localparam int SUM_W      = AMP_W + NUM_BIT;
    localparam int NUM_SAMPLE = 2 ** NUM_BIT;

    typedef logic signed [AMP_W-1:0] amp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } diff_state_t;

endpackage

// File: rtl/grover_sat_narrow.sv
// Narrows an AMP_W+2 bit signed value to an amplitude.
// Build option GROVER_DIFFUSION_SATURATE_EN: clamp to [-128, 127];
// otherwise keep the low AMP_W bits (two's-complement wrap).
module grover_sat_narrow
    import grover_pkg::*;
(
    input  logic signed [AMP_W+1:0] wide,
    output amp_t                    narrow
);

`ifdef GROVER_DIFFUSION_SATURATE_EN
    // Clamp when the top three bits disagree (value outside the amplitude range).
    always_comb begin
        narrow = wide[AMP_W-1:0];
        if (!wide[AMP_W+1] && (wide[AMP_W] || wide[AMP_W-1])) begin
            narrow = {1'b0, {(AMP_W-1){1'b1}}};
        end else if (wide[AMP_W+1] && !(wide[AMP_W] && wide[AMP_W-1])) begin
            narrow = {1'b1, {(AMP_W-1){1'b0}}};
        end
    end
`else
    // Plain truncation to the low AMP_W bits.
    always_comb begin
        narrow = wide[AMP_W-1:0];
    end
`endif

endmodule

// File: rtl/grover_diffusion.sv
// Grover diffusion stage: o_k = 2*mean - i_k over 8 signed amplitudes,
// one shared adder for the sum and one output path, each used for 8 cycles.
// Build option GROVER_DIFFUSION_SATURATE_EN selects saturating narrowing.
//
// state | meaning
// IDLE  | waiting for an input vector, in_ready high
// ACCUM | summing captured amplitudes, one per cycle
// EMIT  | writing one diffused output per cycle
// DONE  | out_valid high, holding outputs until out_ready
module grover_diffusion
    import grover_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AMP_W-1:0] i0,
    input  logic [AMP_W-1:0] i1,
    input  logic [AMP_W-1:0] i2,
    input  logic [AMP_W-1:0] i3,
    input  logic [AMP_W-1:0] i4,
    input  logic [AMP_W-1:0] i5,
    input  logic [AMP_W-1:0] i6,
    input  logic [AMP_W-1:0] i7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AMP_W-1:0] o0,
    output logic [AMP_W-1:0] o1,
    output logic [AMP_W-1:0] o2,
    output logic [AMP_W-1:0] o3,
    output logic [AMP_W-1:0] o4,
    output logic [AMP_W-1:0] o5,
    output logic [AMP_W-1:0] o6,
    output logic [AMP_W-1:0] o7,
    output logic             busy
);

    diff_state_t               state;
    diff_state_t               state_next;
    amp_t                      in_vec [NUM_SAMPLE];
    amp_t                      r      [NUM_SAMPLE];
    amp_t                      o_reg  [NUM_SAMPLE];
    logic signed [SUM_W-1:0]   sum;
    logic [NUM_BIT-1:0]        idx;
    amp_t                      mean;
    amp_t                      r_sel;
    logic signed [AMP_W+1:0]   diff;
    amp_t                      diff_narrow;
    logic                      last_idx;

    // Gather the scalar input ports into an indexable array.
    always_comb begin
        in_vec[0] = i0;
        in_vec[1] = i1;
        in_vec[2] = i2;
        in_vec[3] = i3;
        in_vec[4] = i4;
        in_vec[5] = i5;
        in_vec[6] = i6;
        in_vec[7] = i7;
    end

    // The upper AMP_W bits of the sum are the mean floored toward -inf.
    always_comb begin
        mean     = sum[SUM_W-1:NUM_BIT];
        r_sel    = r[idx];
        diff     = {mean[AMP_W-1], mean, 1'b0} - {{2{r_sel[AMP_W-1]}}, r_sel};
        last_idx = (idx == NUM_BIT'(NUM_SAMPLE - 1));
    end

    grover_sat_narrow u_narrow (
        .wide   (diff),
        .narrow (diff_narrow)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = ACCUM;
            ACCUM:   if (last_idx)  state_next = EMIT;
            EMIT:    if (last_idx)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Datapath: capture, accumulate, then emit one output per cycle.
    // idx wraps 7->0 naturally, so no explicit clear is needed between phases.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum <= '0;
            idx <= '0;
            for (int k = 0; k < NUM_SAMPLE; k++) begin
                r[k]     <= '0;
                o_reg[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < NUM_SAMPLE; k++) begin
                            r[k] <= in_vec[k];
                        end
                        sum <= '0;
                        idx <= '0;
                    end
                end
                ACCUM: begin
                    sum <= sum + {{NUM_BIT{r_sel[AMP_W-1]}}, r_sel};
                    idx <= idx + 1'b1;
                end
                EMIT: begin
                    o_reg[idx] <= diff_narrow;
                    idx        <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Drive the scalar output ports.
    always_comb begin
        o0 = o_reg[0];
        o1 = o_reg[1];
        o2 = o_reg[2];
        o3 = o_reg[3];
        o4 = o_reg[4];
        o5 = o_reg[5];
        o6 = o_reg[6];
        o7 = o_reg[7];
    end

endmodule
